// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV32I funct3 codes,
// FSM state encoding and the access-size lane mask.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_RESP   = 3'd5,
    S_ERR    = 3'd6
  } lsu_state_e;

  // Lane mask for an access of the given size (funct3[1:0]) at offset 0.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/byte-enable shift across a
// two-word window and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [7:0]  lanes,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [4:0]  sh;
  logic [63:0] st_window;
  logic [31:0] ld_word;

  assign sh        = {off, 3'b000};
  assign lanes     = {4'b0000, size_mask(funct3[1:0])} << off;
  assign st_window = {32'b0, wdata} << sh;
  assign wdata_lo  = st_window[31:0];
  assign wdata_hi  = st_window[63:32];
  assign ld_word   = 32'({rdata_hi, rdata_lo} >> sh);

  always_comb begin
    load_data = ld_word;
    case (funct3)
      F3_B:    load_data = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_H:    load_data = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_BU:   load_data = {24'b0, ld_word[7:0]};
      F3_HU:   load_data = {16'b0, ld_word[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit driving a req/gnt/rvalid data-memory port. Misaligned
// accesses spanning two words are split when LSU_MISALIGN_SPLIT_EN is defined.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int AddressWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [2:0]              req_funct3_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  output logic                    resp_valid_o,
  output logic [31:0]             resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [3:0]              mem_be_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  output lsu_state_e              dbg_state
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; a memory request transfers where mem_req_o and
  // mem_gnt_i are both high; mem_rvalid_i is only sampled in WAIT0/WAIT1.
  lsu_state_e state, state_next;

  logic                    we_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic [AddressWidth-1:0] waddr_q;
  logic [31:0]             wdata_q, lo_q, rdata_q;

  logic [7:0]  req_lanes, lanes;
  logic        req_split, req_illegal, accept;
  logic [31:0] wd_lo, wd_hi, load_data, align_lo;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:AddressWidth+2];
  assign accept    = req_valid_i && req_ready_o;
  assign req_lanes = {4'b0000, size_mask(req_funct3_i[1:0])} << req_addr_i[1:0];
  assign req_split = |req_lanes[7:4];

  always_comb begin
    req_illegal = 1'b0;
    if (req_we_i) req_illegal = (req_funct3_i > F3_W);
    else          req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
  end

  // In WAIT1 the low word is already captured; the incoming word is the high one.
  assign align_lo = (state == S_WAIT1) ? lo_q : mem_rdata_i;

  lsu_align u_align (
    .funct3    (f3_q),
    .off       (off_q),
    .wdata     (wdata_q),
    .rdata_lo  (align_lo),
    .rdata_hi  (mem_rdata_i),
    .lanes     (lanes),
    .wdata_lo  (wd_lo),
    .wdata_hi  (wd_hi),
    .load_data (load_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_illegal || (req_split && !SplitEn)) state_next = S_ERR;
          else                                        state_next = S_ISSUE0;
        end
      end
      S_ISSUE0: if (mem_gnt_i) state_next = S_WAIT0;
      S_WAIT0: begin
        if (mem_rvalid_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_next = (|lanes[7:4]) ? S_ISSUE1 : S_RESP;
`else
          state_next = S_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ISSUE1: if (mem_gnt_i) state_next = S_WAIT1;
      S_WAIT1:  if (mem_rvalid_i) state_next = S_RESP;
`endif
      S_RESP:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        off_q   <= req_addr_i[1:0];
        waddr_q <= req_addr_i[AddressWidth+1:2];
        wdata_q <= req_wdata_i;
      end
      if (state == S_WAIT0 && mem_rvalid_i) lo_q <= mem_rdata_i;
      // Result is registered on the edge entering RESP/ERR and held afterwards.
      if (state_next == S_RESP && state != S_RESP) rdata_q <= we_q ? 32'b0 : load_data;
      else if (state_next == S_ERR)                rdata_q <= 32'b0;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'b0;
    if (state == S_ISSUE0) begin
      mem_req_o   = 1'b1;
      mem_be_o    = lanes[3:0];
      mem_addr_o  = waddr_q;
      mem_wdata_o = wd_lo;
    end else if (state == S_ISSUE1) begin
      mem_req_o   = 1'b1;
      mem_be_o    = lanes[7:4];
      mem_addr_o  = waddr_q + AddressWidth'(1);
      mem_wdata_o = wd_hi;
    end
  end

  assign mem_we_o     = mem_req_o && we_q;
  assign req_ready_o  = (state == S_IDLE);
  assign resp_valid_o = (state == S_RESP) || (state == S_ERR);
  assign resp_err_o   = (state == S_ERR);
  assign resp_rdata_o = rdata_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed, table-driven bench for lsu_mem_initiator with a scripted memory
// responder; split vectors follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = '0;
  lsu_state_e    dbg_state;

  lsu_mem_initiator #(.AddressWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Observations of one transaction, filled by do_txn.
  logic [AW-1:0] o_addr[4];
  logic [3:0]    o_be[4];
  logic [31:0]   o_wd[4];
  logic          o_we[4];
  int            o_n, o_lat, o_req_cycles, o_busy_ready;
  bit            o_resp, o_unstable;
  logic          o_err;
  logic [31:0]   o_rdata;

  // Drives one request and plays memory: grant after gnt_delay waiting cycles
  // (first access only), rvalid the cycle after each grant.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int gnt_delay, input bit stray_rvalid);
    int cyc, wait_n;
    bit pend, done, seen;
    logic [AW-1:0] a_first;
    logic [3:0] be_first;
    o_n = 0; o_resp = 0; o_err = 0; o_rdata = '0; o_lat = -1;
    o_req_cycles = 0; o_busy_ready = 0; o_unstable = 0;
    a_first = '0; be_first = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; pend = 0; done = 0; wait_n = 0; seen = 0;
    while (!done && cyc < 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (resp_valid) begin
        o_resp = 1; o_err = resp_err; o_rdata = resp_rdata; o_lat = cyc; done = 1;
      end else begin
        if (req_ready) o_busy_ready++;
        if (pend) begin
          mem_rvalid = 1'b1; mem_rdata = (o_n == 1) ? rd0 : rd1; pend = 0;
        end
        if (mem_req) begin
          if (o_n == 0) o_req_cycles++;
          if (!seen) begin a_first = mem_addr; be_first = mem_be; seen = 1; end
          else if (mem_addr !== a_first || mem_be !== be_first) o_unstable = 1;
          if (o_n > 0 || wait_n >= gnt_delay) begin
            mem_gnt = 1'b1;
            if (o_n < 4) begin
              o_addr[o_n] = mem_addr; o_be[o_n] = mem_be; o_wd[o_n] = mem_wdata; o_we[o_n] = mem_we;
            end
            o_n++; pend = 1; seen = 0;
          end else begin
            wait_n++;
            if (stray_rvalid) begin mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic          we;
    logic [2:0]    f3;
    logic [31:0]   addr, wdata, rd0, rd1;
    int            n_acc;
    logic [AW-1:0] a0;
    logic [3:0]    be0;
    logic [31:0]   wd0;
    logic [AW-1:0] a1;
    logic [3:0]    be1;
    logic [31:0]   wd1;
    logic          err;
    logic [31:0]   rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic we, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd0,
      input logic [31:0] rd1, input int n_acc, input logic [AW-1:0] a0, input logic [3:0] be0,
      input logic [31:0] wd0, input logic [AW-1:0] a1, input logic [3:0] be1,
      input logic [31:0] wd1, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd0 = rd0;
    v.rd1 = rd1; v.n_acc = n_acc; v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1;
    v.be1 = be1; v.wd1 = wd1; v.err = err; v.rdata = rdata;
    vecs.push_back(v);
  endfunction

  initial begin
    int resp_cnt, req_cnt;
    vec_t v;

    add("sw_aligned", 1, F3_W, 32'h10, 32'hDEADBEEF, 0, 0, 1, 10'd4, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    add("sb_off3",    1, F3_B, 32'h13, 32'h000000A5, 0, 0, 1, 10'd4, 4'h8, 32'hA5000000, 0, 0, 0, 0, 0);
    add("lb_neg",     0, F3_B, 32'h13, 0, 32'hA5000000, 0, 1, 10'd4, 4'h8, 0, 0, 0, 0, 0, 32'hFFFFFFA5);
    add("lbu",        0, F3_BU, 32'h13, 0, 32'hA5000000, 0, 1, 10'd4, 4'h8, 0, 0, 0, 0, 0, 32'h000000A5);
    add("lhu_off2",   0, F3_HU, 32'h02, 0, 32'h80010000, 0, 1, 10'd0, 4'hC, 0, 0, 0, 0, 0, 32'h00008001);
    add("lw_aligned", 0, F3_W, 32'h08, 0, 32'h12345678, 0, 1, 10'd2, 4'hF, 0, 0, 0, 0, 0, 32'h12345678);
    add("sh_off2",    1, F3_H, 32'h06, 32'h0000BEEF, 0, 0, 1, 10'd1, 4'hC, 32'hBEEF0000, 0, 0, 0, 0, 0);
    add("lb_pos",     0, F3_B, 32'h01, 0, 32'h00007F00, 0, 1, 10'd0, 4'h2, 0, 0, 0, 0, 0, 32'h0000007F);
    add("lh_off1",    0, F3_H, 32'h01, 0, 32'h00ABCD00, 0, 1, 10'd0, 4'h6, 0, 0, 0, 0, 0, 32'hFFFFABCD);
    add("st_f3_011",  1, 3'b011, 32'h40, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("st_f3_100",  1, 3'b100, 32'h40, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("ld_f3_011",  0, 3'b011, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("ld_f3_110",  0, 3'b110, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("ld_f3_111",  0, 3'b111, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    add("lw_split",   0, F3_W, 32'h05, 0, 32'h44332211, 32'h88776655, 2, 10'd1, 4'hE, 0, 10'd2, 4'h1, 0, 0, 32'h55443322);
    add("lw_wrap",    0, F3_W, 32'hFFE, 0, 32'h22110000, 32'h00004433, 2, 10'd1023, 4'hC, 0, 10'd0, 4'h3, 0, 0, 32'h44332211);
    add("sh_split",   1, F3_H, 32'h03, 32'h0000CAFE, 0, 0, 2, 10'd0, 4'h8, 32'hFE000000, 10'd1, 4'h1, 32'h000000CA, 0, 0);
`else
    add("lw_split",   0, F3_W, 32'h05, 0, 32'h44332211, 32'h88776655, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("lw_wrap",    0, F3_W, 32'hFFE, 0, 32'h22110000, 32'h00004433, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("sh_split",   1, F3_H, 32'h03, 32'h0000CAFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif

    // Reset values, sampled while reset is still asserted.
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_mem_req",    32'(mem_req), 32'd0);
    check("rst_mem_we",     32'(mem_we), 32'd0);
    check("rst_mem_be",     32'(mem_be), 32'd0);
    check("rst_mem_addr",   32'(mem_addr), 32'd0);
    check("rst_mem_wdata",  mem_wdata, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_state",      32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      do_txn(v.we, v.f3, v.addr, v.wdata, v.rd0, v.rd1, 0, 0);
      check({v.name, "_resp"}, 32'(o_resp), 32'd1);
      check({v.name, "_err"}, 32'(o_err), 32'(v.err));
      check({v.name, "_rdata"}, o_rdata, v.rdata);
      check({v.name, "_latency"}, 32'(o_lat), v.err ? 32'd1 : 32'(1 + 2 * v.n_acc));
      check({v.name, "_n_access"}, 32'(o_n), 32'(v.n_acc));
      check({v.name, "_busy_ready"}, 32'(o_busy_ready), 32'd0);
      for (int j = 0; j < v.n_acc && j < 2 && j < o_n; j++) begin
        check($sformatf("%s_addr%0d", v.name, j), 32'(o_addr[j]), 32'(j == 0 ? v.a0 : v.a1));
        check($sformatf("%s_be%0d", v.name, j), 32'(o_be[j]), 32'(j == 0 ? v.be0 : v.be1));
        check($sformatf("%s_wdata%0d", v.name, j), o_wd[j], j == 0 ? v.wd0 : v.wd1);
        check($sformatf("%s_we%0d", v.name, j), 32'(o_we[j]), 32'(v.we));
      end
    end

    // Held result: resp_rdata keeps the last load value once back in IDLE.
    @(negedge clk);
    check("rdata_hold", resp_rdata, 32'h44332211 & {32{1'b0}} | vecs[vecs.size()-1].rdata);

    // Delayed grant with stray rvalid while still requesting.
    do_txn(0, F3_H, 32'h0E, 0, 32'h80010000, 0, 3, 1);
    check("lh_delay_req_cycles", 32'(o_req_cycles), 32'd4);
    check("lh_delay_stable", 32'(o_unstable), 32'd0);
    check("lh_delay_addr", 32'(o_addr[0]), 32'd3);
    check("lh_delay_be", 32'(o_be[0]), 32'hC);
    check("lh_delay_rdata", o_rdata, 32'hFFFF8001);
    check("lh_delay_latency", 32'(o_lat), 32'd6);

    // Reset while waiting for rvalid, then a late rvalid.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_issue", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst_mid_wait0", 32'(dbg_state), 32'(S_WAIT0));
    rst = 1'b1;
    #1;
    check("rst_mid_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    resp_cnt = 0; req_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (resp_valid) resp_cnt++;
      if (mem_req) req_cnt++;
    end
    check("rst_late_resp", 32'(resp_cnt), 32'd0);
    check("rst_late_req", 32'(req_cnt), 32'd0);
    check("rst_late_ready", 32'(req_ready), 32'd1);
    do_txn(0, F3_W, 32'h20, 0, 32'h0BADF00D, 0, 0, 0);
    check("post_rst_lw_rdata", o_rdata, 32'h0BADF00D);
    check("post_rst_lw_latency", 32'(o_lat), 32'd3);
    check("post_rst_lw_addr", 32'(o_addr[0]), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
